piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer
// ----------------------------------------------------------------------------
// Parallel-in / serial-out converter with a one-word holding register, so a
// producer can queue the next word while the current one is still shifting.
// Back-to-back words come out as one unbroken serial stream. The serial
// stream is meant to drive a downstream bit-sequence detector.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         in   1      rising-edge clock for all state
//   clear       in   1      asynchronous active-high reset
//   data_in     in   WIDTH  parallel word offered by the producer
//   data_valid  in   1      data_in holds a word to transfer
//   data_ready  out  1      block can accept a word this cycle
//   ser_out     out  1      serial bit stream (0 whenever idle)
//   ser_valid   out  1      ser_out carries a data bit this cycle
//   word_done   out  1      pulse while the last bit of a word is on ser_out
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] hold_next;
    logic             hold_full;
    logic             hold_full_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             last_bit;

    // Ready only reflects the holding register, never data_valid, so the
    // handshake has no combinational loop through the producer.
    assign data_ready = !hold_full;
    assign accept     = data_valid && data_ready;
    assign last_bit   = (bit_cnt == LAST_BIT);

    // The word advances toward whichever end is being transmitted.
    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

    // All state lives in one register process; clear wipes both the word in
    // flight and any held word, so nothing partial survives a reset.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            hold_reg  <= hold_next;
            hold_full <= hold_full_next;
            bit_cnt   <= cnt_next;
        end
    end

    // Next-state logic. At the last bit of a word, a held word takes priority
    // over a freshly offered one; the fresh one cannot be accepted anyway in
    // that case because ready is low while the holding register is full.
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full;
        cnt_next       = bit_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next = data_in;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (!last_bit) begin
                    shift_next = shifted;
                    cnt_next   = bit_cnt + CNT_W'(1);
                    if (accept) begin
                        hold_next      = data_in;
                        hold_full_next = 1'b1;
                    end
                end else if (hold_full) begin
                    shift_next     = hold_reg;
                    hold_full_next = 1'b0;
                    cnt_next       = '0;
                end else if (accept) begin
                    shift_next = data_in;
                    cnt_next   = '0;
                end else begin
                    // Drain the register so an idle block holds no stale bits.
                    shift_next = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next     = IDLE;
                shift_next     = '0;
                hold_full_next = 1'b0;
                cnt_next       = '0;
            end
        endcase
    end

    // Outputs decode purely from state, so they drop the instant clear rises.
    // The idle line is forced low so it can never feed a downstream detector
    // a phantom pattern.
    assign ser_valid = (state == SHIFT);
    assign word_done = ser_valid && last_bit;
    assign ser_out   = ser_valid ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0])
                                 : 1'b0;

endmodule
